// File: rtl/approx_wallace_mult_scheduler.sv
// Shares one combinational approximate 8x8 Wallace-tree multiplier between two
// requesters: round-robin grant, operand sequencing, per-requester accumulate, tagged result.
module approx_wallace_mult_scheduler #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req0_acc,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic             req1_acc,
    output logic             req1_ready,
    output logic [7:0]       mult_a,
    output logic [7:0]       mult_b,
    input  logic [15:0]      mult_p,
    output logic             res_valid,
    output logic             res_id,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    input  logic             res_ready
);

    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             op_acc;
    logic             op_id;
    logic             last_grant;
    logic [ACC_W-1:0] acc0;
    logic [ACC_W-1:0] acc1;

    logic             grant_any;
    logic             grant_id;
    logic [7:0]       grant_a;
    logic [7:0]       grant_b;
    logic             grant_acc;
    logic [ACC_W-1:0] acc_cur;
    logic [SUM_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_new;
    logic             acc_carry;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_id  = 1'b0;
        grant_any = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
        if ((state == IDLE) && !rst) begin
            grant_any = req0_valid | req1_valid;
        end
        grant_a   = grant_id ? req1_a   : req0_a;
        grant_b   = grant_id ? req1_b   : req0_b;
        grant_acc = grant_id ? req1_acc : req0_acc;
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    // Accumulate or load the selected accumulator with the tree's product as-is.
    always_comb begin
        acc_cur   = op_id ? acc1 : acc0;
        acc_sum   = {1'b0, acc_cur} + SUM_W'(mult_p);
        acc_new   = ACC_W'(mult_p);
        acc_carry = 1'b0;
        if (op_acc) begin
            acc_new   = acc_sum[ACC_W-1:0];
            acc_carry = acc_sum[ACC_W];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = MUL;
            MUL:     next_state = ACC;
            ACC:     next_state = RESP;
            RESP:    if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture, tree drive, accumulators and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_acc     <= 1'b0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            acc0       <= '0;
            acc1       <= '0;
            mult_a     <= 8'd0;
            mult_b     <= 8'd0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_acc     <= grant_acc;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        mult_a     <= grant_a;
                        mult_b     <= grant_b;
                    end
                end
                ACC: begin
                    if (op_id) begin
                        acc1 <= acc_new;
                    end else begin
                        acc0 <= acc_new;
                    end
                    res_data  <= acc_new;
                    res_ovf   <= acc_carry;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    mult_a    <= 8'd0;
                    mult_b    <= 8'd0;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_wallace_mult_scheduler.sv
// Randomized self-checking bench: two scheduler instances (ACC_W 24 and 16) share stimulus,
// each with an exact-product tree stub, compared to an arithmetic accumulator model.
module tb_approx_wallace_mult_scheduler;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_acc, req1_valid, req1_acc;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        res_ready;

    logic        r0_rdy, r1_rdy, rv, rid, rovf;
    logic [7:0]  ma, mb;
    logic [15:0] mp;
    logic [23:0] rdata;

    logic        r0_rdy16, r1_rdy16, rv16, rid16, rovf16;
    logic [7:0]  ma16, mb16;
    logic [15:0] mp16;
    logic [15:0] rdata16;

    int checks = 0;
    int errors = 0;

    longint m_acc24 [2];
    longint m_acc16 [2];
    bit     m_last;

    assign mp   = 16'(ma)   * 16'(mb);
    assign mp16 = 16'(ma16) * 16'(mb16);

    approx_wallace_mult_scheduler #(.ACC_W(24)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_acc(req0_acc), .req0_ready(r0_rdy),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_acc(req1_acc), .req1_ready(r1_rdy),
        .mult_a(ma), .mult_b(mb), .mult_p(mp),
        .res_valid(rv), .res_id(rid), .res_data(rdata), .res_ovf(rovf), .res_ready(res_ready)
    );

    approx_wallace_mult_scheduler #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_acc(req0_acc), .req0_ready(r0_rdy16),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_acc(req1_acc), .req1_ready(r1_rdy16),
        .mult_a(ma16), .mult_b(mb16), .mult_p(mp16),
        .res_valid(rv16), .res_id(rid16), .res_data(rdata16), .res_ovf(rovf16), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc24[0] = 0; m_acc24[1] = 0;
        m_acc16[0] = 0; m_acc16[1] = 0;
        m_last = 1'b1;
    endtask

    // Result = product loaded, or (acc + product) mod 2^W with carry flagged.
    task automatic model_apply(input bit id, input logic [7:0] a, input logic [7:0] b, input bit acc,
                               output logic [23:0] e24, output logic eo24,
                               output logic [15:0] e16, output logic eo16);
        longint p, s24, s16;
        p   = longint'(a) * longint'(b);
        s24 = acc ? m_acc24[id] + p : p;
        s16 = acc ? m_acc16[id] + p : p;
        eo24 = (s24 >= (64'd1 << 24));
        eo16 = (s16 >= (64'd1 << 16));
        m_acc24[id] = s24 % (64'd1 << 24);
        m_acc16[id] = s16 % (64'd1 << 16);
        e24 = 24'(m_acc24[id]);
        e16 = 16'(m_acc16[id]);
        m_last = id;
    endtask

    // One complete transaction from requester id; stall>0 holds res_ready low in RESP
    // while the other requester raises a pending request (7*9, load).
    task automatic issue_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                            input bit acc, input int stall);
        logic [23:0] e24, held;
        logic [15:0] e16;
        logic        eo24, eo16;
        int          n;
        res_ready = (stall == 0);
        if (id) begin
            req1_a = a; req1_b = b; req1_acc = acc; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_acc = acc; req0_valid = 1'b1;
        end
        #1;
        n = 0;
        while (((id ? r1_rdy : r0_rdy) !== 1'b1) && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 8) begin
            errors++;
            $display("FAIL grant_timeout id=%0d ready0=%b ready1=%b", id, r0_rdy, r1_rdy);
        end
        checks++;
        if ((r0_rdy & r1_rdy) !== 1'b0 || {r0_rdy16, r1_rdy16} !== {r0_rdy, r1_rdy}) begin
            errors++;
            $display("FAIL grant_exclusive got %b%b/%b%b want one-hot id=%0d",
                     r0_rdy, r1_rdy, r0_rdy16, r1_rdy16, id);
        end
        model_apply(id, a, b, acc, e24, eo24, e16, eo16);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (stall > 0) begin
            if (id) begin
                req0_a = 8'd7; req0_b = 8'd9; req0_acc = 1'b0; req0_valid = 1'b1;
            end else begin
                req1_a = 8'd7; req1_b = 8'd9; req1_acc = 1'b0; req1_valid = 1'b1;
            end
        end
        checks++;
        if ({ma, mb, ma16, mb16} !== {a, b, a, b} || rv !== 1'b0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mul_stage got a=%0d b=%0d valid=%b want a=%0d b=%0d valid=0", ma, mb, rv, a, b);
        end
        tick();
        checks++;
        if ({ma, mb} !== {a, b} || rv !== 1'b0 || rv16 !== 1'b0) begin
            errors++;
            $display("FAIL acc_stage got a=%0d b=%0d valid=%b want a=%0d b=%0d valid=0", ma, mb, rv, a, b);
        end
        tick();
        checks++;
        if (rv !== 1'b1 || rid !== id || rdata !== e24 || rovf !== eo24) begin
            errors++;
            $display("FAIL result24 got v=%b id=%b d=%0d o=%b want v=1 id=%0d d=%0d o=%b",
                     rv, rid, rdata, rovf, id, e24, eo24);
        end
        checks++;
        if (rv16 !== 1'b1 || rid16 !== id || rdata16 !== e16 || rovf16 !== eo16) begin
            errors++;
            $display("FAIL result16 got v=%b id=%b d=%0d o=%b want v=1 id=%0d d=%0d o=%b",
                     rv16, rid16, rdata16, rovf16, id, e16, eo16);
        end
        checks++;
        if ({ma, mb, ma16, mb16} !== 32'd0) begin
            errors++;
            $display("FAIL resp_operands got a=%0d b=%0d want 0 0", ma, mb);
        end
        held = rdata;
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (rv !== 1'b1 || rdata !== held || rdata16 !== e16 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%0d rdy=%b%b want v=1 d=%0d rdy=00",
                         i, rv, rdata, r0_rdy, r1_rdy, held);
            end
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (rv !== 1'b0 || rv16 !== 1'b0) begin
            errors++;
            $display("FAIL resp_release got valid=%b/%b want 0", rv, rv16);
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({rv, rid, rovf, r0_rdy, r1_rdy} !== 5'd0 || rdata !== 24'd0 || {ma, mb} !== 16'd0 || rdata16 !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b id=%b o=%b rdy=%b%b d=%0d a=%0d b=%0d want all 0",
                     rv, rid, rovf, r0_rdy, r1_rdy, rdata, ma, mb);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({r0_rdy, r1_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant got %b%b want 10", r0_rdy, r1_rdy);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single();
        issue_op(1'b0, 8'd12, 8'd10, 1'b0, 0);
        checks++;
        if (rdata !== 24'd120) begin
            errors++;
            $display("FAIL single_120 got %0d want 120", rdata);
        end
    endtask

    task automatic test_accumulate();
        issue_op(1'b1, 8'd255, 8'd255, 1'b0, 0);
        issue_op(1'b1, 8'd2, 8'd3, 1'b1, 0);
        checks++;
        if (rdata !== 24'd65031) begin
            errors++;
            $display("FAIL accumulate_65031 got %0d want 65031", rdata);
        end
        issue_op(1'b0, 8'd1, 8'd1, 1'b1, 0);
        checks++;
        if (rdata !== 24'd121) begin
            errors++;
            $display("FAIL acc0_untouched got %0d want 121", rdata);
        end
    endtask

    task automatic test_backpressure();
        issue_op(1'b0, 8'd33, 8'd44, 1'b0, 5);
        checks++;
        if ({r0_rdy, r1_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL post_stall_grant got %b%b want 01", r0_rdy, r1_rdy);
        end
        issue_op(1'b1, 8'd7, 8'd9, 1'b0, 0);
    endtask

    task automatic test_wrap();
        issue_op(1'b0, 8'd255, 8'd255, 1'b0, 0);
        issue_op(1'b0, 8'd4, 8'd250, 1'b1, 0);
        checks++;
        if (rdata16 !== 16'd489 || rovf16 !== 1'b1 || rdata !== 24'd66025 || rovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap got d16=%0d o16=%b d24=%0d o24=%b want 489 1 66025 0",
                     rdata16, rovf16, rdata, rovf);
        end
        issue_op(1'b0, 8'd1, 8'd1, 1'b1, 0);
        checks++;
        if (rdata16 !== 16'd490 || rovf16 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_next got d16=%0d o16=%b want 490 0", rdata16, rovf16);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            issue_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
            if (req0_valid || req1_valid) begin
                issue_op(req1_valid, 8'd7, 8'd9, 1'b0, 0);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        req0_a = 8'd200; req0_b = 8'd100; req0_acc = 1'b1; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rv, rv16, rovf, r0_rdy, r1_rdy} !== 5'd0 || {ma, mb, ma16, mb16} !== 32'd0 || rdata !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_op got v=%b a=%0d b=%0d d=%0d want 0 0 0 0", rv, ma, mb, rdata);
        end
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial got valid=%b want 0", rv);
        end
    endtask

    // Both requesters valid continuously: grants alternate from 0, spaced 4 cycles.
    task automatic test_contention();
        bit          q_id [$];
        logic [23:0] q_d24 [$];
        logic [15:0] q_d16 [$];
        logic        q_o24 [$], q_o16 [$];
        logic [23:0] e24;
        logic [15:0] e16;
        logic        eo24, eo16, gid;
        int          grants, prev, cyc;
        res_ready = 1'b1;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_acc = 1'b1; req0_valid = 1'b1;
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_acc = 1'b1; req1_valid = 1'b1;
        #1;
        grants = 0; prev = -1; cyc = 0;
        while ((grants < 12 || q_id.size() > 0) && cyc < 200) begin
            if (grants >= 12) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            if (rv === 1'b1 && q_id.size() > 0) begin
                checks++;
                if (rid !== q_id[0] || rdata !== q_d24[0] || rovf !== q_o24[0] ||
                    rdata16 !== q_d16[0] || rovf16 !== q_o16[0]) begin
                    errors++;
                    $display("FAIL contention_result got id=%b d=%0d o=%b d16=%0d o16=%b want %0d %0d %b %0d %b",
                             rid, rdata, rovf, rdata16, rovf16, q_id[0], q_d24[0], q_o24[0], q_d16[0], q_o16[0]);
                end
                void'(q_id.pop_front()); void'(q_d24.pop_front()); void'(q_o24.pop_front());
                void'(q_d16.pop_front()); void'(q_o16.pop_front());
            end
            if (r0_rdy === 1'b1 || r1_rdy === 1'b1) begin
                gid = r1_rdy;
                checks++;
                if ((r0_rdy & r1_rdy) !== 1'b0 || gid !== ~m_last || (prev >= 0 && cyc - prev != 4)) begin
                    errors++;
                    $display("FAIL contention_grant got id=%b gap=%0d want id=%b gap=4", gid, cyc - prev, ~m_last);
                end
                if (gid) model_apply(1'b1, req1_a, req1_b, req1_acc, e24, eo24, e16, eo16);
                else     model_apply(1'b0, req0_a, req0_b, req0_acc, e24, eo24, e16, eo16);
                q_id.push_back(gid); q_d24.push_back(e24); q_o24.push_back(eo24);
                q_d16.push_back(e16); q_o16.push_back(eo16);
                prev = cyc;
                grants++;
                tick();
                cyc++;
                if (gid) begin
                    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_acc = 1'($urandom);
                end else begin
                    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_acc = 1'($urandom);
                end
            end else begin
                tick();
                cyc++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (grants != 12 || q_id.size() != 0) begin
            errors++;
            $display("FAIL contention_timeout got grants=%0d pending=%0d want 12 0", grants, q_id.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_acc = 1'b0;
        req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_acc = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_accumulate();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid_op();
        test_contention();
        issue_op(1'b1, 8'd3, 8'd3, 1'b1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
